// File: rtl/booth_mul_ctrl.sv
// booth_mul_ctrl: sequential radix-2 Booth controller for an 8x8 signed
// multiply. It runs one Booth iteration per cycle through the ALU's shared
// 9-bit add_sub datapath, and hands back a 16-bit product with a
// start/done handshake.
//
// Optional feature: define BOOTH_ZERO_BYPASS_EN to skip the iterations when
// either operand is zero. The product is then reported one cycle after the
// start is accepted.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; result holds the last product
// CALC  | one Booth iteration per cycle, eight in total
// DONE  | done pulse, result valid; returns to IDLE unconditionally
module booth_mul_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic [WIDTH:0]     as_a,
  output logic [WIDTH:0]     as_b,
  output logic               as_sub,
  input  logic [WIDTH:0]     as_sum
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic             q_1;
  logic [CW-1:0]    cnt;

  logic [1:0]       pair;
  logic             in_calc;
  logic [WIDTH:0]   acc_new;

`ifdef BOOTH_ZERO_BYPASS_EN
  logic             zero_op;
  assign zero_op = (a_in == '0) || (b_in == '0);
`endif

  assign pair    = {mplier[0], q_1};
  assign in_calc = (state == CALC);

  // The adder is steered only during CALC. Pairs 01 and 10 take the adder
  // sum; pairs 00 and 11 keep the accumulator as it is.
  always_comb begin
    as_a    = '0;
    as_b    = '0;
    as_sub  = 1'b0;
    acc_new = acc;
    if (in_calc) begin
      as_a   = acc;
      as_b   = mcand;
      as_sub = (pair == 2'b10);
      if ((pair == 2'b01) || (pair == 2'b10))
        acc_new = as_sum;
    end
  end

  // Control FSM. It also holds the datapath registers and the registered
  // handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      q_1    <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc    <= '0;
            mplier <= b_in;
            q_1    <= 1'b0;
            mcand  <= {a_in[WIDTH-1], a_in};
            cnt    <= '0;
            busy   <= 1'b1;
`ifdef BOOTH_ZERO_BYPASS_EN
            if (zero_op) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= '0;
            end else begin
              state  <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          // Arithmetic right shift of {acc_new, mplier, q_1}.
          acc    <= {acc_new[WIDTH], acc_new[WIDTH:1]};
          mplier <= {acc_new[0], mplier[WIDTH-1:1]};
          q_1    <= mplier[0];
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state  <= DONE;
            done   <= 1'b1;
            // Product is the low 2*WIDTH bits of the shifted {acc, mplier}.
            result <= {acc_new, mplier[WIDTH-1:1]};
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// tb_booth_mul_ctrl: directed bench for booth_mul_ctrl. It supplies the
// 9-bit add_sub datapath model and checks results through a queue of
// expected products.
module tb_booth_mul_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [8:0]  as_a;
  logic [8:0]  as_b;
  logic        as_sub;
  logic [8:0]  as_sum;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

`ifdef BOOTH_ZERO_BYPASS_EN
  localparam int ZERO_N = 1;
`else
  localparam int ZERO_N = 9;
`endif

  booth_mul_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result(result),
    .as_a(as_a), .as_b(as_b), .as_sub(as_sub), .as_sum(as_sum)
  );

  assign as_sum = as_sub ? (as_a - as_b) : (as_a + as_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b;
    exp_q.push_back(prod(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the first negedge after the accepting edge (n=1).
  task automatic wait_done(input string tag, input int exp_n, input logic [7:0] a,
                           input logic [7:0] b, input bit chk_as, output logic [15:0] e);
    int n = 1;
    int busy_n = 0;
    bit timed_out = 0;
    logic prev;
    e = '0;
    while (1) begin
      if (busy) busy_n++;
      if (chk_as && n <= 8) begin
        prev = (n == 1) ? 1'b0 : b[n-2];
        chk({tag, "_as_sub"}, 32'(as_sub), 32'(b[n-1] & ~prev));
        chk({tag, "_as_b"}, 32'(as_b), 32'({a[7], a}));
      end
      if (done) break;
      if (n >= 20) begin
        timed_out = 1;
        chk({tag, "_timeout"}, 32'(done), 32'd1);
        break;
      end
      @(negedge clk);
      n++;
    end
    if (!timed_out) begin
      chk({tag, "_latency"}, 32'(n), 32'(exp_n));
      chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_n));
      if (exp_q.size() == 0) begin
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_result"}, 32'(result), 32'(e));
      end
    end
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    chk({tag, "_as_a_idle"}, 32'(as_a), 32'd0);
  endtask

  task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b,
                    input int exp_n, input bit chk_as);
    logic [15:0] e;
    issue(a, b);
    wait_done(tag, exp_n, a, b, chk_as, e);
    repeat (2) @(negedge clk);
    chk({tag, "_result_held"}, 32'(result), 32'(e));
  endtask

  initial begin
    logic [15:0] e;
    int done_cnt;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_as_a", 32'(as_a), 32'd0);
    chk("rst_as_b", 32'(as_b), 32'd0);
    chk("rst_as_sub", 32'(as_sub), 32'd0);
    rst = 1'b0;

    // Main function and range corners
    op("m3x5", 8'd3, 8'd5, 9, 1'b1);
    chk("m3x5_value", 32'(result), 32'h000F);
    op("mn128xn128", 8'h80, 8'h80, 9, 1'b1);
    chk("mn128xn128_value", 32'(result), 32'h4000);
    op("m127xn128", 8'd127, 8'h80, 9, 1'b0);
    chk("m127xn128_value", 32'(result), 32'hC080);
    op("mn7x6", 8'hF9, 8'd6, 9, 1'b1);
    chk("mn7x6_value", 32'(result), 32'hFFD6);
    op("mn1xn1", 8'hFF, 8'hFF, 9, 1'b1);
    op("m85xn86", 8'h55, 8'hAA, 9, 1'b1);

    // start held high: second operation only after DONE, with new operands
    @(negedge clk);
    start = 1'b1; a_in = 8'd5; b_in = 8'hFD;
    exp_q.push_back(prod(8'd5, 8'hFD));
    @(negedge clk);
    a_in = 8'hF7; b_in = 8'd11;
    exp_q.push_back(prod(8'hF7, 8'd11));
    wait_done("hold1", 9, 8'd5, 8'hFD, 1'b0, e);
    @(negedge clk);
    start = 1'b0;
    chk("hold2_busy", 32'(busy), 32'd1);
    wait_done("hold2", 9, 8'hF7, 8'd11, 1'b1, e);
    chk("hold2_value", 32'(result), 32'hFF9D);

    // Reset in the 4th CALC cycle aborts without a done pulse
    issue(8'd3, 8'd5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_as_a", 32'(as_a), 32'd0);
    chk("abort_as_b", 32'(as_b), 32'd0);
    chk("abort_as_sub", 32'(as_sub), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    op("m2x2", 8'd2, 8'd2, 9, 1'b1);
    chk("m2x2_value", 32'(result), 32'h0004);

    // Zero operand: bypass or full path depending on build
    op("m0x9", 8'd0, 8'd9, ZERO_N, 1'b0);
    chk("m0x9_value", 32'(result), 32'h0000);
    op("m4x7", 8'd4, 8'd7, 9, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
